// File: rtl/uart_rx_oversampled.sv
// Purpose : 8N1 UART receiver with a 2-flop synchronizer, oversampled bit timing, start-glitch rejection and framing-error flagging.
// Latency : 2-cycle synchronizer; oRxValid/oFrameErr strobe one cycle after the mid-stop-bit sample (one tick later with UART_RX_MAJORITY_EN).
// Backpress: none -- the serial line cannot be stalled, so the downstream decoder must accept every oRxValid strobe.
// Option  : define UART_RX_MAJORITY_EN for a 2-of-3 vote around each sample point; undefined gives a single mid-bit sample.
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       iClk,
    input  logic       iRstn,
    input  logic       iRx,
    output logic [7:0] oRxData,
    output logic       oRxValid,
    output logic       oFrameErr,
    output logic       oBusy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int MID     = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the tick after the nominal point, so the start decision moves one tick later;
    // every later decision then lands one tick later too, keeping the same distance from bit edges.
    localparam int START_PT = MID + 1;
`else
    localparam int START_PT = MID;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [1:0]    sync_q, sync_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    state_q, state_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          vld_q, vld_d;
    logic          ferr_q, ferr_d;
    logic          rx_s;
    logic          tick;
    logic          sample;

    assign rx_s = sync_q[1];
    assign tick = (tcnt_q == TW'(DIV - 1));

    // Two-stage synchronizer; both stages idle high like the line
    always_comb begin
        sync_d = {sync_q[0], iRx};
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    // Keep the synchronized line value from the previous two ticks for the vote
    always_comb begin
        hist_d = hist_q;
        if (tick) begin
            hist_d = {hist_q[0], rx_s};
        end
    end

    // History registers
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    // Tick divider, bit-timing FSM, shift register and output strobes
    always_comb begin
        tcnt_d  = tick ? '0 : tcnt_q + TW'(1);
        state_d = state_q;
        sc_d    = sc_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    // Restart the divider so the sample grid is phase-locked to the start edge
                    state_d = S_START;
                    sc_d    = '0;
                    tcnt_d  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sc_q == SW'(START_PT)) begin
                        sc_d  = '0;
                        idx_d = '0;
                        state_d = sample ? S_IDLE : S_DATA;
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (sc_q == SW'(OVERSAMPLE - 1)) begin
                        shift_d[idx_q] = sample;
                        idx_d = idx_q + 3'd1;
                        sc_d  = '0;
                        if (idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (sc_q == SW'(OVERSAMPLE - 1)) begin
                        if (sample) begin
                            data_d  = shift_q;
                            vld_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a stuck-low line is not read as a stream of starts
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            sync_q  <= 2'b11;
            tcnt_q  <= '0;
            state_q <= S_IDLE;
            sc_q    <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            tcnt_q  <= tcnt_d;
            state_q <= state_d;
            sc_q    <= sc_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    assign oRxData   = data_q;
    assign oRxValid  = vld_q;
    assign oFrameErr = ferr_q;
    assign oBusy     = (state_q != S_IDLE);

endmodule
